// File: rtl/alu_result_stage.sv
// Registered ALU result stage: captures RZ/flags on a valid/ready handshake, owns the CCR,
// resolves branch outcomes and queues results toward writeback in a small FIFO.
module alu_result_stage #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [31:0]          ALU_Op,
  input  logic [WIDTH-1:0]     RZ_In,
  input  logic                 CARRY_FLAG,
  input  logic                 OVERFLOW_FLAG,
  input  logic                 ZERO_FLAG,
  input  logic                 NEGATIVE_FLAG,
  input  logic                 INR_FLAG,
  input  logic                 NOP_FLAG,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [WIDTH-1:0]     RZ_Out,
  output logic [31:0]          Op_Out,
  output logic                 Branch_Out,
  output logic                 Taken_Out,
  output logic [31:0]          CCR_Out,
  output logic [CNT_WIDTH-1:0] Retire_Count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] rz;
    logic [31:0]      op;
    logic             br;
    logic             tk;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               head_q, head_d, in_entry;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q, rd_next;
  logic [PTR_W:0]       count_q, count_d;
  logic [6:0]           ccr_q, ccr_d;
  logic [CNT_WIDTH-1:0] retire_q;
  logic                 accept, pop, push, is_nop, hold_flags, is_branch, taken;

  assign In_Ready  = (count_q != (PTR_W+1)'(DEPTH));
  assign Out_Valid = (count_q != '0);
  assign accept    = In_Valid & In_Ready;
  assign pop       = Out_Valid & Out_Ready;
  assign is_nop    = NOP_FLAG | (ALU_Op == '0);
  assign push      = accept & ~is_nop;

  // Branch outcome comes from the incoming flags, never from the stored CCR.
  always_comb begin
    is_branch  = 1'b0;
    taken      = 1'b0;
    hold_flags = 1'b0;
    case (ALU_Op)
      32'd16, 32'd17, 32'd18: hold_flags = 1'b1;
      32'd39: begin is_branch = 1'b1; taken = ZERO_FLAG;      end
      32'd40: begin is_branch = 1'b1; taken = ~ZERO_FLAG;     end
      32'd41: begin is_branch = 1'b1; taken = NEGATIVE_FLAG;  end
      32'd64, 32'd65: begin
        is_branch  = 1'b1;
        taken      = 1'b1;
        hold_flags = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_entry = '{rz: RZ_In, op: ALU_Op, br: is_branch, tk: taken};

  always_comb begin
    ccr_d = ccr_q;
    if (accept) begin
      if (is_nop) begin
        ccr_d[6] = 1'b1;
      end else begin
        ccr_d[6] = 1'b0;
        ccr_d[4] = INR_FLAG;
        if (!hold_flags)
          ccr_d[3:0] = {NEGATIVE_FLAG, ZERO_FLAG, OVERFLOW_FLAG, CARRY_FLAG};
      end
    end
  end

  // Head register is preloaded with the next head; when the FIFO is (or drains to) empty the
  // incoming entry lands at the new read pointer and must be forwarded from the input.
  always_comb begin
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    rd_next = rd_ptr_q + PTR_W'(pop);
    head_d  = head_q;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_next))
        head_d = in_entry;
      else
        head_d = mem_q[rd_next];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset && push)
      mem_q[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ccr_q    <= '0;
      retire_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q <= rd_next;
      count_q  <= count_d;
      head_q   <= head_d;
      ccr_q    <= ccr_d;
      retire_q <= retire_q + CNT_WIDTH'(pop);
    end
  end

  assign RZ_Out       = head_q.rz;
  assign Op_Out       = head_q.op;
  assign Branch_Out   = head_q.br;
  assign Taken_Out    = head_q.tk;
  assign CCR_Out      = {25'd0, ccr_q};
  assign Retire_Count = retire_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed vector table, reset/wrap sequences and randomized
// traffic checked against a queue-based reference model.
module tb_alu_result_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        In_Valid, Out_Ready;
  logic [31:0] ALU_Op, RZ_In;
  logic        C, V, Z, N, INR, NOP;

  logic        In_Ready, Out_Valid, Branch_Out, Taken_Out;
  logic [31:0] RZ_Out, Op_Out, CCR_Out;
  logic [15:0] Retire_Count;

  logic        s_ir, s_ov, s_br, s_tk;
  logic [31:0] s_rz, s_op, s_ccr;
  logic [3:0]  s_rc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 Clock = ~Clock;

  alu_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_WIDTH(16)) u_dut (
    .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .ALU_Op(ALU_Op), .RZ_In(RZ_In), .CARRY_FLAG(C), .OVERFLOW_FLAG(V),
    .ZERO_FLAG(Z), .NEGATIVE_FLAG(N), .INR_FLAG(INR), .NOP_FLAG(NOP),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .RZ_Out(RZ_Out), .Op_Out(Op_Out),
    .Branch_Out(Branch_Out), .Taken_Out(Taken_Out), .CCR_Out(CCR_Out),
    .Retire_Count(Retire_Count)
  );

  // Narrow retire counter instance so the wrap-around is reachable in a short run.
  alu_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_WIDTH(4)) u_small (
    .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(s_ir),
    .ALU_Op(ALU_Op), .RZ_In(RZ_In), .CARRY_FLAG(C), .OVERFLOW_FLAG(V),
    .ZERO_FLAG(Z), .NEGATIVE_FLAG(N), .INR_FLAG(INR), .NOP_FLAG(NOP),
    .Out_Valid(s_ov), .Out_Ready(Out_Ready), .RZ_Out(s_rz), .Op_Out(s_op),
    .Branch_Out(s_br), .Taken_Out(s_tk), .CCR_Out(s_ccr),
    .Retire_Count(s_rc)
  );

  typedef struct {
    logic [31:0] rz;
    logic [31:0] op;
    logic        br;
    logic        tk;
  } ent_t;

  ent_t        q[$];
  ent_t        m_last;
  logic [6:0]  m_ccr;
  int unsigned m_retired;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    ent_t e;
    bit   acc, pp, nop;
    if (Reset) begin
      q.delete();
      m_ccr     = '0;
      m_retired = 0;
      m_last    = '{rz: 32'd0, op: 32'd0, br: 1'b0, tk: 1'b0};
    end else begin
      acc = In_Valid && (q.size() < 2);
      pp  = Out_Ready && (q.size() > 0);
      if (pp) begin
        void'(q.pop_front());
        m_retired++;
      end
      if (acc) begin
        nop = NOP || (ALU_Op == 32'd0);
        if (nop) begin
          m_ccr[6] = 1'b1;
        end else begin
          m_ccr[6] = 1'b0;
          m_ccr[4] = INR;
          if (!(ALU_Op inside {32'd16, 32'd17, 32'd18, 32'd64, 32'd65}))
            m_ccr[3:0] = {N, Z, V, C};
          e.rz = RZ_In;
          e.op = ALU_Op;
          e.br = ALU_Op inside {32'd39, 32'd40, 32'd41, 32'd64, 32'd65};
          e.tk = (ALU_Op == 32'd39) ? Z :
                 (ALU_Op == 32'd40) ? !Z :
                 (ALU_Op == 32'd41) ? N :
                 (ALU_Op == 32'd64 || ALU_Op == 32'd65);
          q.push_back(e);
        end
      end
    end
    if (q.size() > 0) m_last = q[0];
  endtask

  task automatic compare_model();
    check("in_ready", {63'd0, In_Ready}, {63'd0, q.size() != 2});
    check("out_valid", {63'd0, Out_Valid}, {63'd0, q.size() != 0});
    check("ccr", {32'd0, CCR_Out}, {57'd0, m_ccr});
    check("retire", {48'd0, Retire_Count}, 64'(m_retired % 65536));
    check("retire_small", {60'd0, s_rc}, 64'(m_retired % 16));
    check("rz_out", {32'd0, RZ_Out}, {32'd0, m_last.rz});
    check("op_out", {32'd0, Op_Out}, {32'd0, m_last.op});
    check("branch_out", {63'd0, Branch_Out}, {63'd0, m_last.br});
    check("taken_out", {63'd0, Taken_Out}, {63'd0, m_last.tk});
  endtask

  task automatic step();
    @(posedge Clock);
    model_edge();
    #1;
    cyc++;
    compare_model();
  endtask

  task automatic drive(input bit v, input logic [31:0] op, input logic [31:0] rz,
                       input logic [5:0] fl, input bit ordy);
    In_Valid  = v;
    ALU_Op    = op;
    RZ_In     = rz;
    {NOP, INR, N, Z, V, C} = fl;
    Out_Ready = ordy;
  endtask

  typedef struct {
    bit          v;
    logic [31:0] op;
    logic [31:0] rz;
    logic [5:0]  fl;
    bit          ordy;
    bit          e_ir;
    bit          e_ov;
    logic [31:0] e_rz;
    bit          e_br;
    bit          e_tk;
    logic [31:0] e_ccr;
    logic [15:0] e_rc;
  } vec_t;

  function automatic vec_t mk(bit v, logic [31:0] op, logic [31:0] rz, logic [5:0] fl, bit ordy,
                              bit ir, bit ov, logic [31:0] erz, bit br, bit tk,
                              logic [31:0] ccr, logic [15:0] rc);
    vec_t r;
    r = '{v, op, rz, fl, ordy, ir, ov, erz, br, tk, ccr, rc};
    return r;
  endfunction

  vec_t tbl[20];
  logic [31:0] ops[13] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd16, 32'd17, 32'd18,
                           32'd39, 32'd40, 32'd41, 32'd64, 32'd65, 32'd7};

  initial begin
    // flags field order: {NOP, INR, N, Z, V, C}
    tbl[0]  = mk(1, 1,  'h5,  6'h00, 1, 1, 1, 'h5,  0, 0, 'h00, 0);
    tbl[1]  = mk(0, 0,  'h0,  6'h00, 1, 1, 0, 'h0,  0, 0, 'h00, 1);
    tbl[2]  = mk(1, 2,  'hA,  6'h00, 0, 1, 1, 'hA,  0, 0, 'h00, 1);
    tbl[3]  = mk(1, 2,  'hB,  6'h00, 0, 0, 1, 'hA,  0, 0, 'h00, 1);
    tbl[4]  = mk(1, 2,  'hC,  6'h00, 0, 0, 1, 'hA,  0, 0, 'h00, 1);
    tbl[5]  = mk(0, 0,  'h0,  6'h00, 1, 1, 1, 'hB,  0, 0, 'h00, 2);
    tbl[6]  = mk(0, 0,  'h0,  6'h00, 1, 1, 0, 'h0,  0, 0, 'h00, 3);
    tbl[7]  = mk(1, 39, 'h27, 6'h04, 0, 1, 1, 'h27, 1, 1, 'h04, 3);
    tbl[8]  = mk(0, 0,  'h0,  6'h00, 1, 1, 0, 'h0,  0, 0, 'h04, 4);
    tbl[9]  = mk(1, 40, 'h28, 6'h04, 0, 1, 1, 'h28, 1, 0, 'h04, 4);
    tbl[10] = mk(1, 41, 'h29, 6'h08, 1, 1, 1, 'h29, 1, 1, 'h08, 5);
    tbl[11] = mk(1, 3,  'h33, 6'h09, 1, 1, 1, 'h33, 0, 0, 'h09, 6);
    tbl[12] = mk(1, 16, 'h10, 6'h00, 1, 1, 1, 'h10, 0, 0, 'h09, 7);
    tbl[13] = mk(1, 5,  'h55, 6'h20, 1, 1, 0, 'h0,  0, 0, 'h49, 8);
    tbl[14] = mk(1, 0,  'h0,  6'h01, 0, 1, 0, 'h0,  0, 0, 'h49, 8);
    tbl[15] = mk(1, 64, 'h64, 6'h01, 0, 1, 1, 'h64, 1, 1, 'h09, 8);
    tbl[16] = mk(1, 7,  'h77, 6'h10, 0, 0, 1, 'h64, 1, 1, 'h10, 8);
    tbl[17] = mk(1, 8,  'h88, 6'h00, 1, 1, 1, 'h77, 0, 0, 'h10, 9);
    tbl[18] = mk(1, 8,  'h88, 6'h00, 1, 1, 1, 'h88, 0, 0, 'h00, 10);
    tbl[19] = mk(0, 0,  'h0,  6'h00, 1, 1, 0, 'h0,  0, 0, 'h00, 11);

    Reset = 1'b1;
    drive(1, 32'd1, 32'h1234, 6'h0F, 1);
    step();
    step();
    check("rst_out_valid", {63'd0, Out_Valid}, 64'd0);
    check("rst_in_ready", {63'd0, In_Ready}, 64'd1);
    check("rst_ccr", {32'd0, CCR_Out}, 64'd0);
    Reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].rz, tbl[i].fl, tbl[i].ordy);
      step();
      check($sformatf("vec%0d_in_ready", i), {63'd0, In_Ready}, {63'd0, tbl[i].e_ir});
      check($sformatf("vec%0d_out_valid", i), {63'd0, Out_Valid}, {63'd0, tbl[i].e_ov});
      check($sformatf("vec%0d_ccr", i), {32'd0, CCR_Out}, {32'd0, tbl[i].e_ccr});
      check($sformatf("vec%0d_retire", i), {48'd0, Retire_Count}, {48'd0, tbl[i].e_rc});
      if (tbl[i].e_ov) begin
        check($sformatf("vec%0d_rz", i), {32'd0, RZ_Out}, {32'd0, tbl[i].e_rz});
        check($sformatf("vec%0d_branch", i), {63'd0, Branch_Out}, {63'd0, tbl[i].e_br});
        check($sformatf("vec%0d_taken", i), {63'd0, Taken_Out}, {63'd0, tbl[i].e_tk});
      end
    end

    // Bring the narrow counter to all-ones with two entries queued, then reset.
    begin
      int n = 0;
      drive(1, 32'd1, 32'h11, 6'h00, 1);
      while ((m_retired % 16) != 15 && n < 40) begin
        step();
        n++;
      end
      check("wrap_setup_bound", 64'(n < 40), 64'd1);
    end
    drive(1, 32'd2, 32'h22, 6'h00, 0);
    step();
    check("preset_full", {63'd0, In_Ready}, 64'd0);
    check("preset_small_ones", {60'd0, s_rc}, 64'hF);
    Reset = 1'b1;
    drive(1, 32'd39, 32'h33, 6'h04, 1);
    step();
    check("reset_out_valid", {63'd0, Out_Valid}, 64'd0);
    check("reset_rz", {32'd0, RZ_Out}, 64'd0);
    check("reset_op", {32'd0, Op_Out}, 64'd0);
    check("reset_branch", {63'd0, Branch_Out}, 64'd0);
    check("reset_taken", {63'd0, Taken_Out}, 64'd0);
    check("reset_ccr", {32'd0, CCR_Out}, 64'd0);
    check("reset_retire", {48'd0, Retire_Count}, 64'd0);
    check("reset_small_retire", {60'd0, s_rc}, 64'd0);
    check("reset_in_ready", {63'd0, In_Ready}, 64'd1);
    Reset = 1'b0;

    begin
      int n = 0;
      drive(1, 32'd1, 32'h44, 6'h00, 1);
      while ((m_retired % 16) != 15 && n < 40) begin
        step();
        n++;
      end
      check("wrap_run_bound", 64'(n < 40), 64'd1);
    end
    drive(0, 32'd0, 32'h0, 6'h00, 1);
    step();
    check("small_wrap_zero", {60'd0, s_rc}, 64'd0);

    for (int k = 0; k < 3000; k++) begin
      Reset = ($urandom_range(99) == 0);
      drive($urandom_range(3) != 0, ops[$urandom_range(12)], $urandom,
            {($urandom_range(7) == 0), 5'($urandom)}, $urandom_range(2) != 0);
      step();
    end
    Reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
